// File: rtl/return_address_stack.sv
// Return address stack: a hardware call/return stack that feeds the
// returnAddress operand of pcModule when the PC source selects the RA path.
//
// Ports
//   clock          rising-edge system clock
//   reset          asynchronous active-low reset, clears all state
//   clear          synchronous flush: drops all entries, clears sticky flags
//   pc             current PC; pc+PC_INC is stored on a call
//   push           call in this cycle
//   pop            return in this cycle
//   returnAddress  top-of-stack entry (0 when empty), registered state only
//   ra_valid       stack holds at least one entry
//   stack_full     count == DEPTH
//   count          number of valid entries, 0..DEPTH
//   overflow       sticky: push accepted while full (oldest entry lost)
//   underflow      sticky: pop requested while empty
module return_address_stack #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PC_INC = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           pc,
    input  logic                       push,
    input  logic                       pop,
    output logic [WIDTH-1:0]           returnAddress,
    output logic                       ra_valid,
    output logic                       stack_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    tp_q,    tp_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;
    logic             udf_q,   udf_d;

    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] push_addr;

    // Carry out of the increment is discarded: the address wraps mod 2^WIDTH.
    assign push_addr = pc + WIDTH'(PC_INC);

    always_comb begin
        tp_d   = tp_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        wr_en  = 1'b0;
        wr_idx = tp_q;

        if (clear) begin
            tp_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    // When full, tp+1 is the oldest slot, so it is overwritten.
                    tp_d   = tp_q + 1'b1;
                    wr_en  = 1'b1;
                    wr_idx = tp_q + 1'b1;
                    if (cnt_q == FULL_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                2'b01: begin
                    if (cnt_q != '0) begin
                        tp_d  = tp_q - 1'b1;
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        udf_d = 1'b1;
                    end
                end
                2'b11: begin
                    // Return-then-call replaces the top in place; on an empty
                    // stack there is nothing to return from, so act as a push.
                    wr_en = 1'b1;
                    if (cnt_q == '0) begin
                        tp_d   = tp_q + 1'b1;
                        wr_idx = tp_q + 1'b1;
                        cnt_d  = CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            if (wr_en) begin
                mem_q[wr_idx] <= push_addr;
            end
        end
    end

    assign returnAddress = (cnt_q != '0) ? mem_q[tp_q] : '0;
    assign ra_valid      = (cnt_q != '0);
    assign stack_full    = (cnt_q == FULL_CNT);
    assign count         = cnt_q;
    assign overflow      = ovf_q;
    assign underflow     = udf_q;

endmodule

// File: tb/tb_return_address_stack.sv
module tb_return_address_stack;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] pc    = '0;
    logic             push  = 1'b0;
    logic             pop   = 1'b0;
    logic [WIDTH-1:0] returnAddress;
    logic             ra_valid;
    logic             stack_full;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    int tests  = 0;
    int failed = 0;

    return_address_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PC_INC(1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .clear        (clear),
        .pc           (pc),
        .push         (push),
        .pop          (pop),
        .returnAddress(returnAddress),
        .ra_valid     (ra_valid),
        .stack_full   (stack_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    // Reference model: the stack as a queue of addresses, newest at the back.
    logic [WIDTH-1:0] mq[$];
    bit               m_ovf;
    bit               m_udf;

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
        m_udf = 0;
    endtask

    task automatic model_apply(input bit c, input bit pu, input bit po, input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] a;
        a = p + 32'd1;
        if (c) begin
            model_reset();
        end else if (pu && po) begin
            if (mq.size() == 0) mq.push_back(a);
            else mq[mq.size()-1] = a;
        end else if (pu) begin
            mq.push_back(a);
            if (mq.size() > DEPTH) begin
                void'(mq.pop_front());
                m_ovf = 1;
            end
        end else if (po) begin
            if (mq.size() == 0) m_udf = 1;
            else void'(mq.pop_back());
        end
    endtask

    task automatic check_vals(input string name, input logic [WIDTH-1:0] e_ra, input int e_cnt,
                              input bit e_ovf, input bit e_udf);
        bit e_val, e_full;
        e_val  = (e_cnt != 0);
        e_full = (e_cnt == DEPTH);
        tests++;
        if (returnAddress !== e_ra || int'(count) != e_cnt || ra_valid !== e_val ||
            stack_full !== e_full || overflow !== e_ovf || underflow !== e_udf) begin
            failed++;
            $display("FAIL %s: got ra=%h cnt=%0d val=%b full=%b ovf=%b udf=%b, expected ra=%h cnt=%0d val=%b full=%b ovf=%b udf=%b",
                     name, returnAddress, count, ra_valid, stack_full, overflow, underflow,
                     e_ra, e_cnt, e_val, e_full, e_ovf, e_udf);
        end
    endtask

    task automatic check_model(input string name);
        logic [WIDTH-1:0] e_ra;
        e_ra = (mq.size() != 0) ? mq[mq.size()-1] : '0;
        check_vals(name, e_ra, mq.size(), m_ovf, m_udf);
    endtask

    task automatic step(input bit c, input bit pu, input bit po, input logic [WIDTH-1:0] p);
        @(negedge clock);
        clear = c; push = pu; pop = po; pc = p;
        @(posedge clock);
        model_apply(c, pu, po, p);
        #1;
        clear = 0; push = 0; pop = 0;
    endtask

    typedef struct {
        bit               clr;
        bit               pu;
        bit               po;
        logic [WIDTH-1:0] pcv;
        logic [WIDTH-1:0] e_ra;
        int               e_cnt;
        bit               e_ovf;
        bit               e_udf;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{0, 1, 0, 32'd10,         32'd11, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 32'd20,         32'd21, 2, 0, 0});
        vecs.push_back('{0, 1, 1, 32'd40,         32'd41, 2, 0, 0});
        vecs.push_back('{0, 0, 1, 32'd0,          32'd11, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 32'd0,          32'd0,  0, 0, 0});
        vecs.push_back('{0, 0, 1, 32'd0,          32'd0,  0, 0, 1});
        vecs.push_back('{0, 1, 1, 32'd5,          32'd6,  1, 0, 1});
        vecs.push_back('{0, 0, 0, 32'd77,         32'd6,  1, 0, 1});
        vecs.push_back('{1, 1, 0, 32'd50,         32'd0,  0, 0, 0});
        vecs.push_back('{0, 1, 0, 32'hFFFFFFFF,   32'd0,  1, 0, 0});
        vecs.push_back('{1, 0, 0, 32'd0,          32'd0,  0, 0, 0});

        // Reset state
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_vals("reset_state", '0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_vals("idle_after_reset", '0, 0, 0, 0);

        // Table-driven vectors
        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].pu, vecs[i].po, vecs[i].pcv);
            check_vals($sformatf("vec%0d", i), vecs[i].e_ra, vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_udf);
        end

        // Overflow: 9 pushes of pc=0..8 into an 8-deep stack
        for (int i = 0; i < 9; i++) step(0, 1, 0, i);
        check_vals("ovf_fill", 32'd9, 8, 1, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, '0);
            if (i < 7) check_vals($sformatf("ovf_pop%0d", i), 32'(8 - i), 7 - i, 1, 0);
            else       check_vals("ovf_pop_last", 32'd0, 0, 1, 0);
        end
        step(0, 0, 1, '0);
        check_vals("ovf_underflow", 32'd0, 0, 1, 1);
        step(1, 0, 0, '0);
        check_vals("clear_flags", 32'd0, 0, 0, 0);

        // Asynchronous reset in the middle of a push stream
        step(0, 1, 0, 32'd300);
        step(0, 1, 0, 32'd301);
        @(negedge clock);
        push = 1'b1; pc = 32'd100;
        #2;
        reset = 1'b0;
        #1;
        check_vals("async_reset_immediate", '0, 0, 0, 0);
        @(posedge clock);
        #1;
        check_vals("async_reset_held", '0, 0, 0, 0);
        @(negedge clock);
        push = 1'b0;
        reset = 1'b1;
        model_reset();
        step(0, 0, 0, '0);
        check_vals("after_reset_idle", '0, 0, 0, 0);
        step(0, 1, 0, 32'd200);
        check_vals("after_reset_push", 32'd201, 1, 0, 0);

        // Randomized stimulus against the queue model
        for (int i = 0; i < 600; i++) begin
            bit c, pu, po;
            logic [WIDTH-1:0] p;
            c  = ($urandom_range(0, 49) == 0);
            pu = ($urandom_range(0, 99) < 50);
            po = ($urandom_range(0, 99) < 45);
            p  = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF - $urandom_range(0, 1) : $urandom;
            step(c, pu, po, p);
            check_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
